// File: rtl/uart_tx_fifo_if.sv
// Byte-in / serial-out bundle for uart_tx_fifo. The master offers bytes; the slave
// (the transmitter) drives the line, the frame status and the FIFO fill level.
interface uart_tx_fifo_if #(
  parameter int FIFO_DEPTH = 4
) ();
  // Handshake: a byte moves into the FIFO on a rising edge where tx_valid and
  // tx_ready are both high; tx_ready never depends on tx_valid or on a same-cycle pop.
  logic [7:0]                    tx_byte;
  logic                          tx_valid;
  logic                          tx_ready;
  logic                          serial_out;
  logic                          tx_active;
  logic                          tx_done;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic [1:0]                    dbg_state;

  modport master (
    output tx_byte, tx_valid,
    input  tx_ready, serial_out, tx_active, tx_done, fifo_count, dbg_state
  );

  modport slave (
    input  tx_byte, tx_valid,
    output tx_ready, serial_out, tx_active, tx_done, fifo_count, dbg_state
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small byte FIFO; frames run back-to-back while data
// is queued. The FSM state is exported on dbg_state (IDLE=0, START=1, DATA=2, STOP=3).
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 217,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_fifo_if.slave bus
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST_C  = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          serial_q, serial_d;
  logic          done_q, done_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          push, pop, bit_end;

  assign bus.tx_ready   = (count_q < DEPTH_C) && !rst;
  assign bus.serial_out = serial_q;
  assign bus.tx_done    = done_q;
  assign bus.tx_active  = (state_q != IDLE);
  assign bus.fifo_count = count_q;
  assign bus.dbg_state  = state_q;

  assign push    = bus.tx_valid && bus.tx_ready;
  assign bit_end = (clk_cnt_q == LAST_C);

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    serial_d  = serial_q;
    done_d    = 1'b0;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        serial_d  = 1'b1;
        clk_cnt_d = '0;
        if (count_q != '0) begin
          pop      = 1'b1;
          shift_d  = mem_q[rd_ptr_q];
          serial_d = 1'b0;
          state_d  = START;
        end
      end
      START: begin
        if (bit_end) begin
          // Present bit 0 and pre-shift so shift_q[0] always holds the next bit.
          clk_cnt_d = '0;
          bit_idx_d = '0;
          serial_d  = shift_q[0];
          shift_d   = {1'b0, shift_q[7:1]};
          state_d   = DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            serial_d = 1'b1;
            state_d  = STOP;
          end else begin
            serial_d  = shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          // Chain straight into the next start bit when a byte is waiting.
          clk_cnt_d = '0;
          done_d    = 1'b1;
          if (count_q != '0) begin
            pop      = 1'b1;
            shift_d  = mem_q[rd_ptr_q];
            serial_d = 1'b0;
            state_d  = START;
          end else begin
            serial_d = 1'b1;
            state_d  = IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + (AW + 1)'(1);
    else if (pop && !push) count_d = count_q - (AW + 1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      serial_q  <= 1'b1;
      done_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      serial_q  <= serial_d;
      done_q    <= done_d;
      count_q   <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.tx_byte;
  end
endmodule
